fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC register, imem request handshake, IF/ID register
// Define FETCH_SKID_BUF_EN to keep a response that arrives during a stall instead of refetching it.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcStall,
    input  logic        pcFromTaken,
    input  logic [31:0] taken_pc,
    input  logic        IF_ID_stall,
    input  logic        IF_ID_flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_inst,
    output logic        IF_ID_valid
);

    typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic        ifid_valid_q, ifid_valid_d;
`ifdef FETCH_SKID_BUF_EN
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic        buf_full_q, buf_full_d;
`endif

    logic        resp;
    logic        stall;
    logic [31:0] redirect_pc;
    logic        tpc_unused;

    assign resp        = req_q & imem_rvalid;
    assign stall       = pcStall | IF_ID_stall;
    assign redirect_pc = {taken_pc[31:2], 2'b00};
    assign tpc_unused  = ^taken_pc[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        req_addr_d   = req_addr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
`ifdef FETCH_SKID_BUF_EN
        buf_pc_d     = buf_pc_q;
        buf_inst_d   = buf_inst_q;
        buf_full_d   = buf_full_q;
`endif
        case (state_q)
            FETCH: begin
                if (pcFromTaken) begin
                    pc_d         = redirect_pc;
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
`ifdef FETCH_SKID_BUF_EN
                    buf_full_d   = 1'b0;
`endif
                    // An unanswered request cannot be dropped; wait it out in DRAIN.
                    if (req_q && !imem_rvalid) begin
                        state_d = DRAIN;
                    end else begin
                        req_d      = 1'b1;
                        req_addr_d = redirect_pc;
                    end
                end else if (IF_ID_flush) begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
`ifdef FETCH_SKID_BUF_EN
                    // pc already moved past the buffered word; rewind so it is fetched again.
                    if (buf_full_q) begin
                        pc_d       = buf_pc_q;
                        buf_full_d = 1'b0;
                    end
`endif
                    if (!req_q || imem_rvalid) begin
                        req_d      = 1'b1;
                        req_addr_d = pc_d;
                    end
                end else if (stall) begin
                    if (resp) begin
                        req_d = 1'b0;
`ifdef FETCH_SKID_BUF_EN
                        buf_pc_d   = req_addr_q;
                        buf_inst_d = imem_rdata;
                        buf_full_d = 1'b1;
                        pc_d       = pc_q + 32'd4;
`endif
                    end
                end
`ifdef FETCH_SKID_BUF_EN
                else if (buf_full_q) begin
                    ifid_pc_d    = buf_pc_q;
                    ifid_inst_d  = buf_inst_q;
                    ifid_valid_d = 1'b1;
                    buf_full_d   = 1'b0;
                    req_d        = 1'b1;
                    req_addr_d   = pc_q;
                end
`endif
                else if (resp) begin
                    ifid_pc_d    = req_addr_q;
                    ifid_inst_d  = imem_rdata;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_q + 32'd4;
                    req_d        = 1'b1;
                    req_addr_d   = pc_q + 32'd4;
                end else begin
                    ifid_valid_d = 1'b0;
                    ifid_inst_d  = NOP_INST;
                    if (!req_q) begin
                        req_d      = 1'b1;
                        req_addr_d = pc_q;
                    end
                end
            end
            DRAIN: begin
                ifid_valid_d = 1'b0;
                ifid_inst_d  = NOP_INST;
                if (pcFromTaken) begin
                    pc_d = redirect_pc;
                end
                if (resp) begin
                    state_d    = FETCH;
                    req_d      = 1'b1;
                    req_addr_d = pc_d;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            req_addr_q   <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
`ifdef FETCH_SKID_BUF_EN
            buf_pc_q     <= 32'h0;
            buf_inst_q   <= NOP_INST;
            buf_full_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            req_addr_q   <= req_addr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_SKID_BUF_EN
            buf_pc_q     <= buf_pc_d;
            buf_inst_q   <= buf_inst_d;
            buf_full_q   <= buf_full_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = req_addr_q;
    assign IF_ID_pc    = ifid_pc_q;
    assign IF_ID_inst  = ifid_inst_q;
    assign IF_ID_valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with an instruction-stream reference model
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcStall, pcFromTaken, IF_ID_stall, IF_ID_flush;
    logic [31:0] taken_pc;
    logic        imem_req, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] IF_ID_pc, IF_ID_inst;
    logic        IF_ID_valid;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference state: next architectural pc expected in IF/ID, plus memory latency bookkeeping.
    logic [31:0] exp_pc;
    int          busy, lat, delay_n, lat_fixed, watch_cnt, valid_cnt;
    bit          lat_rand, spurious_en;
    logic [31:0] delay_addr, watch_addr;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .pcStall(pcStall), .pcFromTaken(pcFromTaken),
        .taken_pc(taken_pc), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst),
        .IF_ID_valid(IF_ID_valid)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic clear_ctl();
        pcStall = 0; IF_ID_stall = 0; pcFromTaken = 0; IF_ID_flush = 0; taken_pc = 0;
    endtask

    task automatic cycle();
        logic        p_rst, p_taken, p_flush, p_stall, p_req, p_rv, o_valid;
        logic [31:0] p_tpc, p_addr, o_pc, o_inst;
        p_rst = rst_n; p_taken = pcFromTaken; p_flush = IF_ID_flush; p_tpc = taken_pc;
        p_stall = pcStall | IF_ID_stall; p_req = imem_req; p_rv = imem_rvalid; p_addr = imem_addr;
        o_pc = IF_ID_pc; o_inst = IF_ID_inst; o_valid = IF_ID_valid;
        @(posedge clk); #1;
        if (p_rst === 1'b1) begin
            n_checks++;
            if (p_taken) begin
                if (IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP) begin
                    n_fail++; $display("FAIL sb_taken_bubble: valid=%b inst=%h, required valid=0 inst=%h", IF_ID_valid, IF_ID_inst, NOP);
                end
                exp_pc = {p_tpc[31:2], 2'b00};
            end else if (p_flush) begin
                if (IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP) begin
                    n_fail++; $display("FAIL sb_flush_bubble: valid=%b inst=%h, required valid=0 inst=%h", IF_ID_valid, IF_ID_inst, NOP);
                end
            end else if (p_stall) begin
                if ({IF_ID_pc, IF_ID_inst, IF_ID_valid} !== {o_pc, o_inst, o_valid}) begin
                    n_fail++; $display("FAIL sb_stall_hold: got pc=%h inst=%h v=%b, required pc=%h inst=%h v=%b", IF_ID_pc, IF_ID_inst, IF_ID_valid, o_pc, o_inst, o_valid);
                end
            end else if (IF_ID_valid === 1'b1) begin
                if (IF_ID_pc !== exp_pc || IF_ID_inst !== memf(exp_pc)) begin
                    n_fail++; $display("FAIL sb_stream: got pc=%h inst=%h, required pc=%h inst=%h", IF_ID_pc, IF_ID_inst, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                valid_cnt++;
            end else if (IF_ID_inst !== NOP) begin
                n_fail++; $display("FAIL sb_bubble_inst: inst=%h, required %h", IF_ID_inst, NOP);
            end
            if (p_req && p_rv) begin
                busy = 0;
                if (p_addr == watch_addr) watch_cnt++;
            end else if (p_req) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    n_fail++; $display("FAIL imem_hold: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, p_addr);
                end
            end
        end
        if (imem_req === 1'b1) begin
            if (busy == 0) begin
                busy = 1;
                if (imem_addr == delay_addr) lat = delay_n;
                else if (lat_rand)          lat = $urandom_range(0, 3);
                else                        lat = lat_fixed;
            end
            if (lat == 0) begin
                imem_rvalid = 1; imem_rdata = memf(imem_addr);
            end else begin
                imem_rvalid = 0; imem_rdata = $urandom; lat--;
            end
        end else begin
            imem_rvalid = spurious_en && ($urandom_range(0, 3) == 0);
            imem_rdata  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; clear_ctl(); imem_rvalid = 0; imem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        busy = 0; lat = 0; exp_pc = 32'h0;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_ctl(); imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, required 0", imem_req); end
        n_checks++;
        if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", IF_ID_valid); end
        n_checks++;
        if (IF_ID_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h, required %h", IF_ID_inst, NOP); end
        n_checks++;
        if (IF_ID_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, required 0", IF_ID_pc); end
        busy = 0; lat = 0; exp_pc = 32'h0; imem_rvalid = 0;
        rst_n = 1;
        cycle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL req_rise: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'(4 * i) || IF_ID_inst !== memf(32'(4 * i))) begin
                n_fail++; $display("FAIL zero_wait_%0d: v=%b pc=%h inst=%h, required v=1 pc=%h", i, IF_ID_valid, IF_ID_pc, IF_ID_inst, 32'(4 * i));
            end
        end
    endtask

    task automatic test_slow_response();
        bit found = 0;
        do_reset();
        delay_addr = 32'h8; delay_n = 3;
        for (int k = 0; k < 10 && !found; k++) begin
            cycle();
            if (imem_req === 1'b1 && imem_addr === 32'h8) found = 1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL slow_reach: request at 0x8 not seen, required within 10 cycles"); end
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
                n_fail++; $display("FAIL slow_hold_%0d: req=%b addr=%h, required req=1 addr=8", j, imem_req, imem_addr);
            end
            cycle();
            n_checks++;
            if (j < 3 && (IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP)) begin
                n_fail++; $display("FAIL slow_bubble_%0d: v=%b inst=%h, required v=0 inst=%h", j, IF_ID_valid, IF_ID_inst, NOP);
            end else if (j == 3 && (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h8)) begin
                n_fail++; $display("FAIL slow_deliver: v=%b pc=%h, required v=1 pc=8", IF_ID_valid, IF_ID_pc);
            end
        end
        delay_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_stall();
        bit found = 0;
        int edges = 0;
        int exp_edges, exp_fetches;
`ifdef FETCH_SKID_BUF_EN
        exp_edges = 1; exp_fetches = 1;
`else
        exp_edges = 2; exp_fetches = 2;
`endif
        do_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (IF_ID_valid === 1'b1 && IF_ID_pc === 32'h10) found = 1;
        end
        watch_addr = 32'h14; watch_cnt = 0;
        pcStall = 1; IF_ID_stall = 1;
        for (int s = 0; s < 2; s++) begin
            cycle();
            n_checks++;
            if (IF_ID_pc !== 32'h10 || IF_ID_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold_%0d: pc=%h v=%b, required pc=10 v=1", s, IF_ID_pc, IF_ID_valid);
            end
        end
        clear_ctl();
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            cycle();
            edges++;
            if (IF_ID_valid === 1'b1 && IF_ID_pc === 32'h14) found = 1;
        end
        n_checks++;
        if (!found || edges != exp_edges) begin
            n_fail++; $display("FAIL stall_resume: 0x14 after %0d edges (found=%0b), required %0d", edges, found, exp_edges);
        end
        repeat (2) cycle();
        n_checks++;
        if (watch_cnt != exp_fetches) begin
            n_fail++; $display("FAIL stall_fetch_count: 0x14 fetched %0d times, required %0d", watch_cnt, exp_fetches);
        end
        watch_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_taken_drain();
        bit found = 0;
        int drained = 0;
        do_reset();
        delay_addr = 32'h20; delay_n = 3;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (imem_req === 1'b1 && imem_addr === 32'h20) found = 1;
        end
        pcFromTaken = 1; taken_pc = 32'h200;
        cycle();
        clear_ctl();
        for (int k = 0; k < 10 && imem_req === 1'b1 && imem_addr === 32'h20; k++) begin
            drained++;
            n_checks++;
            if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL drain_bubble: v=%b, required 0", IF_ID_valid); end
            cycle();
        end
        n_checks++;
        if (drained != 3) begin n_fail++; $display("FAIL drain_len: %0d cycles at 0x20, required 3", drained); end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL drain_redirect: req=%b addr=%h, required req=1 addr=200", imem_req, imem_addr);
        end
        cycle();
        n_checks++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h200) begin
            n_fail++; $display("FAIL drain_target: v=%b pc=%h, required v=1 pc=200", IF_ID_valid, IF_ID_pc);
        end
        delay_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_taken_stall();
        bit found = 0;
        do_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (IF_ID_valid === 1'b1 && IF_ID_pc === 32'h8) found = 1;
        end
        pcFromTaken = 1; taken_pc = 32'h203; pcStall = 1; IF_ID_stall = 1;
        cycle();
        clear_ctl();
        n_checks++;
        if (IF_ID_valid !== 1'b0 || IF_ID_inst !== NOP) begin
            n_fail++; $display("FAIL taken_stall_bubble: v=%b inst=%h, required v=0 inst=%h", IF_ID_valid, IF_ID_inst, NOP);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL taken_stall_addr: req=%b addr=%h, required req=1 addr=200", imem_req, imem_addr);
        end
        cycle();
        n_checks++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h200) begin
            n_fail++; $display("FAIL taken_stall_target: v=%b pc=%h, required v=1 pc=200", IF_ID_valid, IF_ID_pc);
        end
    endtask

    task automatic test_reset_mid_wrap();
        do_reset();
        lat_fixed = 5;
        repeat (2) cycle();
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL async_drop: req=%b, required 0", imem_req); end
        lat_fixed = 0;
        do_reset();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        cycle();
        n_checks++;
        if (IF_ID_valid !== 1'b0) begin n_fail++; $display("FAIL late_resp_ignored: v=%b, required 0", IF_ID_valid); end
        pcFromTaken = 1; taken_pc = 32'hFFFF_FFFC;
        cycle();
        clear_ctl();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_req: req=%b addr=%h, required req=1 addr=fffffffc", imem_req, imem_addr);
        end
        cycle();
        n_checks++;
        if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: v=%b pc=%h addr=%h, required v=1 pc=fffffffc addr=0", IF_ID_valid, IF_ID_pc, imem_addr);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_rand = 1; spurious_en = 1; valid_cnt = 0;
        for (int c = 0; c < 2000; c++) begin
            pcStall     = ($urandom_range(0, 3) == 0);
            IF_ID_stall = ($urandom_range(0, 5) == 0);
            pcFromTaken = ($urandom_range(0, 19) == 0);
            IF_ID_flush = ($urandom_range(0, 19) == 0);
            taken_pc    = $urandom;
            cycle();
        end
        clear_ctl();
        lat_rand = 0; spurious_en = 0;
        n_checks++;
        if (valid_cnt < 200) begin n_fail++; $display("FAIL random_progress: %0d instructions, required >= 200", valid_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        busy = 0; lat = 0; lat_fixed = 0; lat_rand = 0; spurious_en = 0;
        delay_addr = 32'hFFFF_FFFF; delay_n = 0; watch_addr = 32'hFFFF_FFFF; watch_cnt = 0;
        valid_cnt = 0; exp_pc = 32'h0;
        test_reset();
        test_zero_wait();
        test_slow_response();
        test_stall();
        test_taken_drain();
        test_taken_stall();
        test_reset_mid_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
